// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on valid/ready, shifts it out one bit per clock with frame markers.
// Latency: first bit on ser_out the cycle after the accept edge; GAP idle cycles follow each frame.
// Backpressure: load_ready low while a frame or gap is in progress (except the last bit when GAP==0, allowing back-to-back frames).
`timescale 1ns/1ps
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRELAST  = CW'(WIDTH - 2);
    localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             busy_q, busy_d;
    logic             last_bit;
    logic             accept;

    assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST);
    assign load_ready = rst_n && ((state_q == ST_IDLE) || (last_bit && (GAP == 0)));
    assign accept     = load_valid && load_ready;

    // shreg holds the bits still to be sent, aligned so the next one is at the shift-out end
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        gap_cnt_d     = gap_cnt_q;
        ser_out_d     = 1'b1;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        if (accept) begin
            shreg_d       = LSB_FIRST ? (load_data >> 1) : (load_data << 1);
            ser_out_d     = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            cnt_d         = '0;
            state_d       = ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (last_bit) begin
                        if (GAP > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d       = cnt_q + 1'b1;
                        ser_out_d   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
                        shreg_d     = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                        ser_valid_d = 1'b1;
                        frame_end_d = (cnt_q == PRELAST);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            gap_cnt_q     <= '0;
            ser_out_q     <= 1'b1;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Three serializer configurations driven together; a cycle-count model predicts handshake/valid timing and a scoreboard holds expected bits.
`timescale 1ns/1ps
module tb_piso_serializer;
    localparam int NI = 3;
    localparam int WS [NI] = '{8, 8, 2};
    localparam int LS [NI] = '{1, 0, 1};
    localparam int GS [NI] = '{2, 0, 0};

    typedef struct packed {
        logic b;
        logic s;
        logic e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lv [NI];
    logic [31:0] ld [NI];
    logic        lr [NI];
    logic        so [NI];
    logic        sv [NI];
    logic        fs [NI];
    logic        fe [NI];
    logic        bz [NI];

    exp_t exp_buf [NI][$];
    int   rd  [NI];
    int   rem [NI];
    int   total = 0;
    int   bad   = 0;
    int   tmo   = 0;
    logic done  = 1'b0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .GAP(2)) u_a (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_data(ld[0][7:0]), .load_ready(lr[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));
    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .GAP(0)) u_b (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_data(ld[1][7:0]), .load_ready(lr[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));
    piso_serializer #(.WIDTH(2), .LSB_FIRST(1'b1), .GAP(0)) u_c (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_data(ld[2][1:0]), .load_ready(lr[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));

    function automatic logic model_ready(input int i, input int r);
        return (r == 0) || (GS[i] == 0 && r == 1);
    endfunction

    // Reference: rem counts the cycles still owed to the current frame plus its gap.
    initial begin
        for (int i = 0; i < NI; i++) rem[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NI; i++) rem[i] = 0;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    logic acc;
                    acc = lv[i] && model_ready(i, rem[i]);
                    if (rem[i] > 0) rem[i] = rem[i] - 1;
                    if (acc) begin
                        rem[i] = WS[i] + GS[i];
                        for (int k = 0; k < WS[i]; k++) begin
                            int idx;
                            idx = (LS[i] != 0) ? k : WS[i] - 1 - k;
                            exp_buf[i].push_back(exp_t'{ld[i][idx], (k == 0), (k == WS[i] - 1)});
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t got=%0d want=%0d", nm, i, $time, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) rd[i] = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                for (int i = 0; i < NI; i++) begin
                    rd[i] = exp_buf[i].size();
                    chk("rst_ser_out", i, so[i], 1);
                    chk("rst_ser_valid", i, sv[i], 0);
                    chk("rst_frame_start", i, fs[i], 0);
                    chk("rst_frame_end", i, fe[i], 0);
                    chk("rst_busy", i, bz[i], 0);
                    chk("rst_load_ready", i, lr[i], 0);
                end
            end else begin
                for (int i = 0; i < NI; i++) begin
                    logic ev;
                    ev = rem[i] > GS[i];
                    chk("load_ready", i, lr[i], model_ready(i, rem[i]));
                    chk("busy", i, bz[i], rem[i] > 0);
                    chk("ser_valid", i, sv[i], ev);
                    if (ev && rd[i] < exp_buf[i].size()) begin
                        exp_t e;
                        e = exp_buf[i][rd[i]];
                        rd[i]++;
                        chk("ser_out", i, so[i], e.b);
                        chk("frame_start", i, fs[i], e.s);
                        chk("frame_end", i, fe[i], e.e);
                    end else if (ev) begin
                        chk("scoreboard_underflow", i, rd[i], exp_buf[i].size() + 1);
                    end else begin
                        chk("idle_ser_out", i, so[i], 1);
                        chk("idle_frame_start", i, fs[i], 0);
                        chk("idle_frame_end", i, fe[i], 0);
                    end
                end
                if (done) begin
                    chk("handshake_timeouts", 0, tmo, 0);
                    for (int i = 0; i < NI; i++) chk("bits_left", i, exp_buf[i].size() - rd[i], 0);
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $finish;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the word until the handshake completes; returns 1ns after the accepting edge.
    task automatic send(input int i, input logic [31:0] w);
        logic r;
        int   n;
        lv[i] = 1'b1;
        ld[i] = w;
        n = 0;
        r = 1'b0;
        while (!r && n < 60) begin
            @(negedge clk);
            r = lr[i];
            @(posedge clk);
            #1;
            n++;
        end
        if (!r) tmo++;
        lv[i] = 1'b0;
        ld[i] = $urandom;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            lv[i] = 1'b0;
            ld[i] = '0;
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        send(0, 32'hA5);
        send(0, 32'hFF);
        cycles(12);
        send(1, 32'h3C);
        cycles(10);
        send(1, 32'h0F);
        send(1, 32'hF0);
        cycles(10);
        send(2, 32'h2);
        cycles(5);
        send(0, 32'h5A);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cycles(5);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++) begin
                lv[i] = ($urandom_range(0, 3) != 0);
                ld[i] = $urandom;
            end
            cycles(1);
        end
        for (int i = 0; i < NI; i++) lv[i] = 1'b0;
        cycles(30);
        done = 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end
endmodule
